// File: rtl/mult32_seq_ctrl_if.sv
// Request/response and partial-product array signals of the 32x32
// sequential multiply controller. The controller takes the slave view.
interface mult32_seq_ctrl_if;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic [1:0]  signed_i;
  logic        high_i;
  logic [15:0] pp_a_o;
  logic [15:0] pp_b_o;
  logic [31:0] pp_res_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;

  modport slave (
    input  valid_i, operand_a_i, operand_b_i, signed_i, high_i, pp_res_i, ready_i,
    output ready_o, pp_a_o, pp_b_o, valid_o, result_o
  );

  modport master (
    output valid_i, operand_a_i, operand_b_i, signed_i, high_i, pp_res_i, ready_i,
    input  ready_o, pp_a_o, pp_b_o, valid_o, result_o
  );
endinterface

// File: rtl/mult32_seq_ctrl.sv
// Sequencing controller for a 32x32 multiply on a shared 16x16 unsigned
// array: four half-word partial products, one signed correction cycle,
// then the selected 32-bit half is held until the consumer takes it.
module mult32_seq_ctrl #(
  parameter int STEPS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  kill_i,
  output logic                  busy_o,
  mult32_seq_ctrl_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, MUL, CORR, DONE} state_t;

  localparam logic [1:0] STEP_LAST = 2'(STEPS - 1);

  state_t      state_q;
  logic [1:0]  step_q;
  logic [63:0] acc_q, acc_d;
  logic [31:0] a_q, b_q;
  logic [1:0]  sgn_q;
  logic        high_q;
  logic        valid_q;
  logic [31:0] result_q;

  logic [63:0] pp_shifted;
  logic [63:0] corr_a, corr_b;

  // Partial-product weight and the next accumulator value for MUL / CORR.
  // Steps 1 and 2 are the cross terms, both weighted by 2^16.
  always_comb begin
    pp_shifted = {32'h0, bus.pp_res_i};
    case (step_q)
      2'd0:    pp_shifted = {32'h0, bus.pp_res_i};
      2'd3:    pp_shifted = {bus.pp_res_i, 32'h0};
      default: pp_shifted = {16'h0, bus.pp_res_i, 16'h0};
    endcase
    // A negative signed operand contributes an extra -2^32 * other operand.
    corr_a = (sgn_q[1] & a_q[31]) ? {b_q, 32'h0} : 64'h0;
    corr_b = (sgn_q[0] & b_q[31]) ? {a_q, 32'h0} : 64'h0;
    acc_d  = acc_q;
    case (state_q)
      MUL:     acc_d = acc_q + pp_shifted;
      CORR:    acc_d = acc_q - corr_a - corr_b;
      default: acc_d = acc_q;
    endcase
  end

  // Half-word selection for the array; step[1] picks A's half, step[0] B's.
  always_comb begin
    bus.pp_a_o = 16'h0;
    bus.pp_b_o = 16'h0;
    if (state_q == MUL) begin
      bus.pp_a_o = step_q[1] ? a_q[31:16] : a_q[15:0];
      bus.pp_b_o = step_q[0] ? b_q[31:16] : b_q[15:0];
    end
  end

  assign bus.ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign bus.valid_o  = valid_q;
  assign bus.result_o = result_q;

  // Controller FSM; kill wins over every transition including acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      step_q   <= 2'd0;
      acc_q    <= 64'h0;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      sgn_q    <= 2'b00;
      high_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= 32'h0;
    end else if (kill_i) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.valid_i) begin
            a_q     <= bus.operand_a_i;
            b_q     <= bus.operand_b_i;
            sgn_q   <= bus.signed_i;
            high_q  <= bus.high_i;
            acc_q   <= 64'h0;
            step_q  <= 2'd0;
            state_q <= MUL;
          end
        end
        MUL: begin
          acc_q  <= acc_d;
          step_q <= step_q + 2'd1;
          if (step_q == STEP_LAST) state_q <= CORR;
        end
        CORR: begin
          acc_q    <= acc_d;
          result_q <= high_q ? acc_d[63:32] : acc_d[31:0];
          valid_q  <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          if (bus.ready_i) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult32_seq_ctrl.md
Name: mult32_seq_ctrl

Overview:
- Sequencing controller for a 32x32 multiply built on a shared 16x16 unsigned partial-product array.
- Accepts one operation per valid/ready handshake.
- Steps the four 16-bit half-word pairs through the external array, one per cycle, and accumulates them into a 64-bit register.
- Applies a signed-operand correction cycle, then returns the low or high 32 bits. Fits the MUL/MULH/MULHSU/MULHU class of operations.

Parameters:
- STEPS, 4, number of partial-product cycles; fixed, must equal 4.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- valid_i  in  1  operation request
- ready_o  out  1  controller can accept an operation
- operand_a_i  in  32  multiplicand
- operand_b_i  in  32  multiplier
- signed_i  in  2  [1]: A is signed; [0]: B is signed
- high_i  in  1  1: return product[63:32]; 0: return product[31:0]
- kill_i  in  1  synchronous abort
- pp_a_o  out  16  half-word of A driven to the array
- pp_b_o  out  16  half-word of B driven to the array
- pp_res_i  in  32  unsigned product pp_a_o*pp_b_o, combinational in the same cycle
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts result
- result_o  out  32  selected product half
- busy_o  out  1  state != IDLE

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE, step=0, acc=0, operand/mode registers=0.
  - valid_o=0, result_o=0, pp_a_o=0, pp_b_o=0, busy_o=0.
  - ready_o=1 once reset is released.
- States: IDLE, MUL, CORR, DONE.
- ready_o = (state==IDLE). No overlap between operations.
- IDLE:
  - On a clock edge with valid_i&&ready_o, latch A, B, signed_i and high_i; clear acc; step=0; go to MUL.
  - Input values at any other time are ignored.
- MUL: each cycle drives the half-word pair for the current step:
  - step0: pp_a_o=A[15:0], pp_b_o=B[15:0]; acc += pp_res_i<<0
  - step1: A[15:0], B[31:16]; acc += pp_res_i<<16
  - step2: A[31:16], B[15:0]; acc += pp_res_i<<16
  - step3: A[31:16], B[31:16]; acc += pp_res_i<<32
  - All additions are 64-bit, mod 2^64.
  - step increments each cycle; after step3 go to CORR.
- pp_a_o and pp_b_o are 0 outside MUL.
- CORR (one cycle, always taken so latency is fixed):
  - acc -= (signed_i[1]&A[31]) ? {B,32'h0} : 0
  - acc -= (signed_i[0]&B[31]) ? {A,32'h0} : 0
  - Both subtractions are mod 2^64.
  - Register result_o = high ? acc'[63:32] : acc'[31:0]; set valid_o=1; go to DONE.
- DONE:
  - Hold valid_o and result_o stable until ready_i=1.
  - On the edge with valid_o&&ready_i: valid_o=0, go to IDLE; ready_o=1 the following cycle.
- Latency: acceptance edge T, MUL edges T+1..T+4, CORR edge T+5; valid_o is high from after T+5. Minimum throughput is one operation per 7 cycles.
- kill_i in any state:
  - next state IDLE, valid_o=0, step=0; result_o holds its last value.
  - kill_i has priority over the handshake in IDLE: no operation is accepted on that edge.
- kill_i and ready_i both high in DONE: outcome is identical (go to IDLE).
- rst_n asserted mid-operation: everything returns to reset values immediately and no result is produced.
- valid_i held high while busy: no effect; the request is sampled only while ready_o=1.

Test Plan:
- Unsigned (signed_i=00, high_i=1), A=B=0xFFFFFFFF -> result_o=0xFFFFFFFE. Repeat with high_i=0 -> 0x00000001. Check valid_o rises exactly 5 edges after acceptance.
- Signed x signed (signed_i=11), A=B=0xFFFFFFFF -> high=0x00000000, low=0x00000001. Also A=B=0x80000000 -> high=0x40000000, low=0x00000000.
- Signed x unsigned (signed_i=10), A=0xFFFFFFFF, B=0xFFFFFFFF -> high=0xFFFFFFFF, low=0x00000001.
- Sequencing check, A=0x12345678, B=0x9ABCDEF0, bench array model:
  - pp_a_o/pp_b_o sequence must be 5678/DEF0, 5678/9ABC, 1234/DEF0, 1234/9ABC.
  - Unsigned low result must be 0x242D2080.
- Backpressure and kill:
  - Hold ready_i=0 for 10 cycles in DONE -> valid_o and result_o stable, ready_o=0. Then ready_i=1 -> ready_o=1 next cycle.
  - Assert kill_i during step2 -> IDLE, no valid_o pulse. A new request is accepted next cycle and gives the correct product.
- Reset with async rst_n low in mid-MUL, asserted between edges -> valid_o=0, busy_o=0, pp_a_o=0 immediately. After release the first operation is correct.
